// File: rtl/el2_lsu_dccm_ctl.sv
// DCCM front-end: zero-fills the array after reset, then arbitrates LSU and DMA
// onto the single-ported memory, with a starvation bound that favours a waiting DMA.
module el2_lsu_dccm_ctl #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39,
   parameter int STARVE_MAX       = 7,
   parameter logic [DCCM_FDATA_WIDTH-1:0] INIT_DATA = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        lsu_rden,
   input  logic                        lsu_wren,
   input  logic [DCCM_BITS-1:0]        lsu_rd_addr_lo,
   input  logic [DCCM_BITS-1:0]        lsu_rd_addr_hi,
   input  logic [DCCM_BITS-1:0]        lsu_wr_addr_lo,
   input  logic [DCCM_BITS-1:0]        lsu_wr_addr_hi,
   input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wr_data_lo,
   input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wr_data_hi,
   output logic                        lsu_stall,
   input  logic                        dma_req_valid,
   input  logic                        dma_req_write,
   input  logic [DCCM_BITS-1:0]        dma_req_addr,
   input  logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata,
   output logic                        dma_req_ready,
   output logic                        dma_rsp_valid,
   output logic [DCCM_FDATA_WIDTH-1:0] dma_rsp_rdata,
   output logic                        dccm_wren,
   output logic                        dccm_rden,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
   output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
   output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
   input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
   output logic                        init_done
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [DCCM_BITS-1:0] INIT_LAST = {{(DCCM_BITS-2){1'b1}}, 2'b00};
   localparam logic [7:0]           STARVE_LIM = 8'(STARVE_MAX);

   state_t               state, state_nxt;
   logic [DCCM_BITS-1:0] init_addr;
   logic [7:0]           starve_cnt;
   logic                 lsu_act, starve_hit, dma_grant;
   logic                 rsp_vld_p1;

   assign lsu_act    = lsu_rden | lsu_wren;
   assign starve_hit = (starve_cnt == STARVE_LIM);

   always_comb begin
      state_nxt       = state;
      lsu_stall       = 1'b0;
      dma_grant       = 1'b0;
      dccm_wren       = lsu_wren;
      dccm_rden       = lsu_rden;
      dccm_wr_addr_lo = lsu_wr_addr_lo;
      dccm_wr_addr_hi = lsu_wr_addr_hi;
      dccm_rd_addr_lo = lsu_rd_addr_lo;
      dccm_rd_addr_hi = lsu_rd_addr_hi;
      dccm_wr_data_lo = lsu_wr_data_lo;
      dccm_wr_data_hi = lsu_wr_data_hi;
      case (state)
         INIT: begin
            dccm_wren       = 1'b1;
            dccm_rden       = 1'b0;
            dccm_wr_addr_lo = init_addr;
            dccm_wr_addr_hi = init_addr;
            dccm_wr_data_lo = INIT_DATA;
            dccm_wr_data_hi = INIT_DATA;
            lsu_stall       = 1'b1;
            if (init_addr == INIT_LAST) state_nxt = RUN;
         end
         RUN: begin
            dma_grant = dma_req_valid & (~lsu_act | starve_hit);
            lsu_stall = lsu_act & dma_req_valid & starve_hit;
            // A granted DMA word owns both banks; the LSU retries its request.
            if (dma_grant) begin
               dccm_wren       = dma_req_write;
               dccm_rden       = ~dma_req_write;
               dccm_wr_addr_lo = dma_req_addr;
               dccm_wr_addr_hi = dma_req_addr;
               dccm_rd_addr_lo = dma_req_addr;
               dccm_rd_addr_hi = dma_req_addr;
               dccm_wr_data_lo = dma_req_wdata;
               dccm_wr_data_hi = dma_req_wdata;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   assign dma_req_ready = dma_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT;
         init_addr  <= '0;
         starve_cnt <= '0;
         rsp_vld_p1 <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         init_done  <= (state_nxt == RUN);
         rsp_vld_p1 <= dma_grant & ~dma_req_write;
         if (state == INIT) init_addr <= init_addr + DCCM_BITS'(4);
         if (!dma_req_valid || dma_grant)
            starve_cnt <= '0;
         else if (state == RUN && !starve_hit)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

   // ---- response stage p1: memory read data arrives the cycle after rden ----
   assign dma_rsp_valid = rsp_vld_p1;
   assign dma_rsp_rdata = rsp_vld_p1 ? dccm_rd_data_lo : '0;

endmodule

// File: tb/tb_el2_lsu_dccm_ctl.sv
// Bench for el2_lsu_dccm_ctl: small DCCM model with one-cycle read latency,
// DMA read responses checked through an expected-data queue.
module tb_el2_lsu_dccm_ctl;
   localparam int AW = 8;
   localparam int DW = 39;
   localparam logic [DW-1:0] IDATA = 39'h0A_5A5A_5A5A;

   logic          clk, rst;
   logic          lsu_rden, lsu_wren;
   logic [AW-1:0] lsu_rd_addr_lo, lsu_rd_addr_hi, lsu_wr_addr_lo, lsu_wr_addr_hi;
   logic [DW-1:0] lsu_wr_data_lo, lsu_wr_data_hi;
   logic          lsu_stall;
   logic          dma_req_valid, dma_req_write, dma_req_ready;
   logic [AW-1:0] dma_req_addr;
   logic [DW-1:0] dma_req_wdata;
   logic          dma_rsp_valid;
   logic [DW-1:0] dma_rsp_rdata;
   logic          dccm_wren, dccm_rden;
   logic [AW-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
   logic [DW-1:0] dccm_wr_data_lo, dccm_wr_data_hi, dccm_rd_data_lo;
   logic          init_done;

   el2_lsu_dccm_ctl #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW), .STARVE_MAX(3),
                      .INIT_DATA(IDATA)) dut (
      .clk(clk), .rst(rst),
      .lsu_rden(lsu_rden), .lsu_wren(lsu_wren),
      .lsu_rd_addr_lo(lsu_rd_addr_lo), .lsu_rd_addr_hi(lsu_rd_addr_hi),
      .lsu_wr_addr_lo(lsu_wr_addr_lo), .lsu_wr_addr_hi(lsu_wr_addr_hi),
      .lsu_wr_data_lo(lsu_wr_data_lo), .lsu_wr_data_hi(lsu_wr_data_hi),
      .lsu_stall(lsu_stall),
      .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
      .dma_req_ready(dma_req_ready),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
      .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
      .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
      .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
      .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
      .dccm_rd_data_lo(dccm_rd_data_lo),
      .init_done(init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DCCM model, lo bank only, cleared at time zero.
   logic [DW-1:0] mem [64];
   logic          mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else if (dccm_wren) begin
         mem[dccm_wr_addr_lo[7:2]] <= dccm_wr_data_lo;
      end
      if (dccm_rden) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[7:2]];
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_d;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      lsu_rden = 0; lsu_wren = 0;
      lsu_rd_addr_lo = '0; lsu_rd_addr_hi = '0; lsu_wr_addr_lo = '0; lsu_wr_addr_hi = '0;
      lsu_wr_data_lo = '0; lsu_wr_data_hi = '0;
      dma_req_valid = 0; dma_req_write = 0; dma_req_addr = '0; dma_req_wdata = '0;
   endtask

   // Advance one clock, then check any DMA response due this cycle.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      chk("rsp_valid", 64'(dma_rsp_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         exp_d = exp_q.pop_front();
         chk("rsp_rdata", 64'(dma_rsp_rdata), 64'(exp_d));
      end
   endtask

   task automatic init_seq(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         chk("init_wren", 64'(dccm_wren), 64'd1);
         chk("init_rden", 64'(dccm_rden), 64'd0);
         chk("init_addr_lo", 64'(dccm_wr_addr_lo), 64'(i * 4));
         chk("init_addr_hi", 64'(dccm_wr_addr_hi), 64'(i * 4));
         chk("init_data", 64'(dccm_wr_data_lo), 64'(IDATA));
         chk("init_stall", 64'(lsu_stall), 64'd1);
         chk("init_ready", 64'(dma_req_ready), 64'd0);
         chk("init_done_lo", 64'(init_done), 64'd0);
         cyc();
      end
   endtask

   logic [6:0] vp;

   initial begin
      mem_clr = 1; rst = 1; idle();
      lsu_rden = 1; lsu_rd_addr_lo = 8'h10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_clr = 0;
      #1;
      chk("rst_done", 64'(init_done), 64'd0);
      chk("rst_rsp", 64'(dma_rsp_valid), 64'd0);
      rst = 0;
      init_seq(64);
      #1;
      chk("init_done", 64'(init_done), 64'd1);
      chk("run_stall", 64'(lsu_stall), 64'd0);

      // LSU read pass-through
      idle(); lsu_rden = 1; lsu_rd_addr_lo = 8'h10; lsu_rd_addr_hi = 8'h14;
      #1;
      chk("lsu_rden", 64'(dccm_rden), 64'd1);
      chk("lsu_wren", 64'(dccm_wren), 64'd0);
      chk("lsu_ra_lo", 64'(dccm_rd_addr_lo), 64'h10);
      chk("lsu_ra_hi", 64'(dccm_rd_addr_hi), 64'h14);
      chk("lsu_rd_stall", 64'(lsu_stall), 64'd0);
      cyc();

      // LSU write pass-through
      idle(); lsu_wren = 1; lsu_wr_addr_lo = 8'h50; lsu_wr_addr_hi = 8'h54;
      lsu_wr_data_lo = 39'h11; lsu_wr_data_hi = 39'h22;
      #1;
      chk("lsu_w_wren", 64'(dccm_wren), 64'd1);
      chk("lsu_w_rden", 64'(dccm_rden), 64'd0);
      chk("lsu_wa_hi", 64'(dccm_wr_addr_hi), 64'h54);
      chk("lsu_wd_lo", 64'(dccm_wr_data_lo), 64'h11);
      chk("lsu_wd_hi", 64'(dccm_wr_data_hi), 64'h22);
      cyc();

      // DMA read with LSU idle
      idle(); dma_req_valid = 1; dma_req_addr = 8'h20;
      #1;
      chk("dma_rd_ready", 64'(dma_req_ready), 64'd1);
      chk("dma_rd_rden", 64'(dccm_rden), 64'd1);
      chk("dma_rd_wren", 64'(dccm_wren), 64'd0);
      chk("dma_ra_lo", 64'(dccm_rd_addr_lo), 64'h20);
      chk("dma_ra_hi", 64'(dccm_rd_addr_hi), 64'h20);
      exp_q.push_back(IDATA);
      cyc();

      // DMA write, then read it back
      idle(); dma_req_valid = 1; dma_req_write = 1; dma_req_addr = 8'h40; dma_req_wdata = 39'h12345;
      #1;
      chk("dma_wr_ready", 64'(dma_req_ready), 64'd1);
      chk("dma_wr_wren", 64'(dccm_wren), 64'd1);
      chk("dma_wr_rden", 64'(dccm_rden), 64'd0);
      chk("dma_wa_lo", 64'(dccm_wr_addr_lo), 64'h40);
      chk("dma_wd_lo", 64'(dccm_wr_data_lo), 64'h12345);
      chk("dma_wd_hi", 64'(dccm_wr_data_hi), 64'h12345);
      cyc();
      idle(); dma_req_valid = 1; dma_req_addr = 8'h40;
      #1;
      chk("dma_rb_ready", 64'(dma_req_ready), 64'd1);
      exp_q.push_back(39'h12345);
      cyc();
      idle();
      cyc();

      // Starvation: LSU always busy, DMA read always pending
      idle(); lsu_rden = 1; lsu_rd_addr_lo = 8'h30; lsu_rd_addr_hi = 8'h34;
      dma_req_valid = 1; dma_req_addr = 8'h24;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("stv_ready", 64'(dma_req_ready), 64'(k == 3 || k == 7));
         chk("stv_stall", 64'(lsu_stall), 64'(k == 3 || k == 7));
         chk("stv_addr", 64'(dccm_rd_addr_lo), (k == 3 || k == 7) ? 64'h24 : 64'h30);
         if (k == 3 || k == 7) exp_q.push_back(IDATA);
         cyc();
      end

      // A gap in dma_req_valid restarts the starvation count
      vp = 7'b1111011;
      for (int k = 0; k < 7; k++) begin
         dma_req_valid = vp[k];
         #1;
         chk("gap_ready", 64'(dma_req_ready), 64'(k == 6));
         chk("gap_stall", 64'(lsu_stall), 64'(k == 6));
         if (k == 6) exp_q.push_back(IDATA);
         cyc();
      end
      idle();
      cyc();

      // Reset in RUN while a DMA read is granted: response dropped
      dma_req_valid = 1; dma_req_addr = 8'h20; rst = 1;
      cyc();
      idle(); lsu_rden = 1;
      #1;
      chk("rr_done", 64'(init_done), 64'd0);
      chk("rr_addr", 64'(dccm_wr_addr_lo), 64'h0);
      chk("rr_stall", 64'(lsu_stall), 64'd1);
      rst = 0;

      // Reset in the middle of INIT at address 0x80
      init_seq(32);
      #1;
      chk("mi_addr", 64'(dccm_wr_addr_lo), 64'h80);
      rst = 1;
      cyc();
      rst = 0;
      init_seq(64);
      #1;
      chk("mi_done", 64'(init_done), 64'd1);
      chk("mi_stall", 64'(lsu_stall), 64'd0);
      idle(); dma_req_valid = 1; dma_req_addr = 8'h40;
      #1;
      chk("mi_ready", 64'(dma_req_ready), 64'd1);
      exp_q.push_back(IDATA);
      cyc();
      idle();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
